// File: rtl/hls_deadlock_persist_monitor_pkg.sv
// Shared types and helpers for the HLS deadlock persistence monitor.
// Optional diagnostics in the top are enabled by HLS_DEADLOCK_DIAG_EN.
package hls_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } state_e;

    localparam int unsigned EVT_CNT_W = 16;
    localparam int unsigned MAX_AXIS  = 32;

    // Index of the lowest set bit; 0 when the vector is all zero.
    function automatic int unsigned lowest_set_idx(input logic [MAX_AXIS-1:0] vec);
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_AXIS; i++) begin
            if (vec[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hls_deadlock_persist_monitor_cnt.sv
// Saturating persistence counter for the deadlock monitor.
module hls_deadlock_persist_cnt #(
    parameter int unsigned THRESHOLD = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_thresh
);

    localparam int unsigned CNT_W = $clog2(THRESHOLD + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_W'(THRESHOLD))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_thresh = (cnt_q == CNT_W'(THRESHOLD - 1));

endmodule

// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock monitor: raises block after a candidate persists THRESHOLD cycles.
// Define HLS_DEADLOCK_DIAG_EN to add event_cnt / first_idx / first_vld ports.
module hls_deadlock_persist_monitor
    import hls_deadlock_pkg::*;
#(
    parameter int unsigned         N_AXIS    = 2,
    parameter int unsigned         N_INST    = 1,
    parameter logic [N_AXIS-1:0]   AXIS_MASK = {N_AXIS{1'b1}},
    parameter int unsigned         THRESHOLD = 16,
    parameter bit                  STICKY    = 1'b0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [N_AXIS-1:0]                    axis_block_sigs,
    input  logic [(N_INST > 0 ? N_INST : 1)-1:0] inst_idle_sigs,
    input  logic [(N_INST > 0 ? N_INST : 1)-1:0] inst_block_sigs,
    input  logic                                 clear,
    output logic                                 block,
    output logic [N_AXIS-1:0]                    block_src
`ifdef HLS_DEADLOCK_DIAG_EN
    ,
    output logic [EVT_CNT_W-1:0]                 event_cnt,
    output logic [(N_AXIS > 1 ? $clog2(N_AXIS) : 1)-1:0] first_idx,
    output logic                                 first_vld
`endif
);

    logic [N_AXIS-1:0] axis_masked;
    logic              axis_hit;
    logic              inst_hit;
    logic              cand;

    assign axis_masked = axis_block_sigs & AXIS_MASK;
    assign axis_hit    = |axis_masked;

    generate
        if (N_INST > 0) begin : g_inst
            assign inst_hit = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
        end else begin : g_no_inst
            assign inst_hit = 1'b0;
        end
    endgenerate

    assign cand = axis_hit | inst_hit;

    state_e            state_q, state_d;
    logic              block_q, block_d;
    logic [N_AXIS-1:0] src_q, src_d;
    logic              cnt_inc, cnt_clr, at_thresh, enter;

    hls_deadlock_persist_cnt #(
        .THRESHOLD (THRESHOLD)
    ) u_cnt (
        .clock     (clock),
        .reset     (reset),
        .inc       (cnt_inc),
        .clr       (cnt_clr),
        .at_thresh (at_thresh)
    );

    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        enter   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cand) begin
                        cnt_inc = 1'b1;
                        if (THRESHOLD == 1) begin
                            state_d = BLOCKED;
                            enter   = 1'b1;
                        end else begin
                            state_d = SUSPECT;
                        end
                    end
                end
                SUSPECT: begin
                    if (!cand) begin
                        state_d = IDLE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        if (at_thresh) begin
                            state_d = BLOCKED;
                            enter   = 1'b1;
                        end
                    end
                end
                BLOCKED: begin
                    if (!STICKY && !cand) begin
                        state_d = IDLE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Snapshot is taken only on the entry edge and dropped on exit.
    always_comb begin
        block_d = (state_d == BLOCKED);
        src_d   = '0;
        if (enter) begin
            src_d = axis_masked;
        end else if (state_d == BLOCKED) begin
            src_d = src_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            block_q <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            src_q   <= src_d;
        end
    end

    assign block     = block_q;
    assign block_src = src_q;

`ifdef HLS_DEADLOCK_DIAG_EN
    localparam int unsigned FIRST_W = (N_AXIS > 1) ? $clog2(N_AXIS) : 1;

    logic [EVT_CNT_W-1:0] evt_q, evt_d;
    logic [FIRST_W-1:0]   fidx_q, fidx_d;
    logic                 fvld_q, fvld_d;

    always_comb begin
        evt_d  = evt_q;
        fidx_d = fidx_q;
        fvld_d = fvld_q;
        if (enter) begin
            if (evt_q != '1) begin
                evt_d = evt_q + 1'b1;
            end
            if (!fvld_q) begin
                fidx_d = FIRST_W'(lowest_set_idx(MAX_AXIS'(axis_masked)));
                fvld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            evt_q  <= '0;
            fidx_q <= '0;
            fvld_q <= 1'b0;
        end else begin
            evt_q  <= evt_d;
            fidx_q <= fidx_d;
            fvld_q <= fvld_d;
        end
    end

    assign event_cnt = evt_q;
    assign first_idx = fidx_q;
    assign first_vld = fvld_q;
`endif

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Randomized bench for hls_deadlock_persist_monitor with a run-length reference model.
module tb_hls_deadlock_persist_monitor;

    logic       clock = 1'b0;
    logic       reset, clear;
    logic [1:0] axis, idle, iblk;

    always #5 clock = ~clock;

    logic [2:0] b_o;
    logic [1:0] s_o [3];
`ifdef HLS_DEADLOCK_DIAG_EN
    logic [15:0] e_o [3];
    logic [2:0]  fi_o;
    logic [2:0]  fv_o;
`endif

    // d0: default-like, d1: sticky with two instances, d2: one-cycle, channel 1 masked
    hls_deadlock_persist_monitor #(
        .N_AXIS(2), .N_INST(1), .AXIS_MASK(2'b11), .THRESHOLD(4), .STICKY(1'b0)
    ) d0 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis),
        .inst_idle_sigs(idle[0:0]), .inst_block_sigs(iblk[0:0]), .clear(clear),
        .block(b_o[0]), .block_src(s_o[0])
`ifdef HLS_DEADLOCK_DIAG_EN
        , .event_cnt(e_o[0]), .first_idx(fi_o[0:0]), .first_vld(fv_o[0])
`endif
    );

    hls_deadlock_persist_monitor #(
        .N_AXIS(2), .N_INST(2), .AXIS_MASK(2'b11), .THRESHOLD(4), .STICKY(1'b1)
    ) d1 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis),
        .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clear),
        .block(b_o[1]), .block_src(s_o[1])
`ifdef HLS_DEADLOCK_DIAG_EN
        , .event_cnt(e_o[1]), .first_idx(fi_o[1:1]), .first_vld(fv_o[1])
`endif
    );

    hls_deadlock_persist_monitor #(
        .N_AXIS(2), .N_INST(2), .AXIS_MASK(2'b01), .THRESHOLD(1), .STICKY(1'b0)
    ) d2 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis),
        .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clear),
        .block(b_o[2]), .block_src(s_o[2])
`ifdef HLS_DEADLOCK_DIAG_EN
        , .event_cnt(e_o[2]), .first_idx(fi_o[2:2]), .first_vld(fv_o[2])
`endif
    );

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: block follows the length of the current run of candidate cycles.
    typedef struct {
        int         run;
        bit         blk;
        logic [1:0] src;
        int         evt;
        bit         fvld;
        int         fidx;
    } model_t;

    int         cfg_th [3] = '{4, 4, 1};
    bit         cfg_st [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] cfg_mk [3] = '{2'b11, 2'b11, 2'b01};
    int         cfg_ni [3] = '{1, 2, 2};

    model_t m [3];
    bit     started = 1'b0;

    function automatic model_t step(input model_t cur, input int k);
        model_t r;
        bit     all_ok, any_b, cand, nowblk, enter;
        r      = cur;
        all_ok = 1'b1;
        any_b  = 1'b0;
        for (int i = 0; i < cfg_ni[k]; i++) begin
            all_ok = all_ok & (idle[i] | iblk[i]);
            any_b  = any_b | iblk[i];
        end
        cand = (|(axis & cfg_mk[k])) || (cfg_ni[k] > 0 && all_ok && any_b);
        if (reset) begin
            r = '{run: 0, blk: 1'b0, src: 2'b00, evt: 0, fvld: 1'b0, fidx: 0};
            return r;
        end
        if (clear) begin
            r.run = 0;
            r.blk = 1'b0;
            r.src = 2'b00;
            return r;
        end
        r.run  = cand ? cur.run + 1 : 0;
        nowblk = cfg_st[k] ? (cur.blk || r.run >= cfg_th[k]) : (r.run >= cfg_th[k]);
        enter  = nowblk && !cur.blk;
        r.blk  = nowblk;
        r.src  = enter ? (axis & cfg_mk[k]) : (nowblk ? cur.src : 2'b00);
        if (enter) begin
            if (r.evt < 65535) r.evt = r.evt + 1;
            if (!cur.fvld) begin
                r.fvld = 1'b1;
                r.fidx = r.src[0] ? 0 : (r.src[1] ? 1 : 0);
            end
        end
        return r;
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) m[k] = step(m[k], k);
        if (reset) started = 1'b1;
    end

    always @(negedge clock) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("d%0d.block", k), int'(b_o[k]), int'(m[k].blk));
                chk($sformatf("d%0d.block_src", k), int'(s_o[k]), int'(m[k].src));
`ifdef HLS_DEADLOCK_DIAG_EN
                chk($sformatf("d%0d.event_cnt", k), int'(e_o[k]), m[k].evt);
                chk($sformatf("d%0d.first_vld", k), int'(fv_o[k]), int'(m[k].fvld));
                chk($sformatf("d%0d.first_idx", k), int'(fi_o[k]), m[k].fidx);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    bit gap_pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

    initial begin
        reset = 1'b1; clear = 1'b0; axis = 2'b00; idle = 2'b00; iblk = 2'b00;
        tick(); tick();
        reset = 1'b0;
        chk("reset_block", int'(b_o[0]), 0);
        chk("reset_src", int'(s_o[0]), 0);

        // hold channel 1 for 6 cycles
        axis = 2'b10;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("hold_pre%0d", i), int'(b_o[0]), 0);
            chk("mask_d2_hold", int'(b_o[2]), 0);
        end
        tick();
        chk("hold_rise", int'(b_o[0]), 1);
        chk("hold_src", int'(s_o[0]), 2);
        tick(); tick();
        axis = 2'b00;
        tick();
        chk("release_block", int'(b_o[0]), 0);
        chk("release_src", int'(s_o[0]), 0);
        chk("sticky_hold", int'(b_o[1]), 1);
        chk("sticky_src", int'(s_o[1]), 2);
        pulse_clear();
        chk("sticky_clear", int'(b_o[1]), 0);
        axis = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("sticky_rearm%0d", i), int'(b_o[1]), 0);
        end
        tick();
        chk("sticky_rearm_rise", int'(b_o[1]), 1);
        axis = 2'b00;
        tick();
        pulse_clear();
        tick();

        // one-cycle gap restarts the count
        for (int i = 0; i < 8; i++) begin
            axis = gap_pat[i] ? 2'b01 : 2'b00;
            tick();
            chk($sformatf("gap_c%0d", i + 1), int'(b_o[0]), (i == 7) ? 1 : 0);
        end
        axis = 2'b00;
        tick();
        chk("gap_release", int'(b_o[0]), 0);
        pulse_clear();

        // instance-only deadlock
        idle = 2'b01; iblk = 2'b10;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("inst_pre%0d", i), int'(b_o[1]), 0);
        end
        tick();
        chk("inst_rise", int'(b_o[1]), 1);
        chk("inst_src", int'(s_o[1]), 0);
        chk("inst_d0_single", int'(b_o[0]), 0);
        idle = 2'b11; iblk = 2'b00;
        pulse_clear();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("inst_all_idle", int'(b_o[1]), 0);
        end
        idle = 2'b00;

        // masked channel never forms a candidate
        axis = 2'b10;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mask_d2", int'(b_o[2]), 0);
        end
        axis = 2'b00;
        tick();

        // reset in the middle of SUSPECT
        axis = 2'b01;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("rst_mid_pre%0d", i), int'(b_o[0]), 0);
        end
        tick();
        chk("rst_mid_rise", int'(b_o[0]), 1);
        axis = 2'b00;
        tick();

`ifdef HLS_DEADLOCK_DIAG_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int ev = 0; ev < 3; ev++) begin
            axis = (ev == 1) ? 2'b01 : 2'b10;
            repeat (4) tick();
            axis = 2'b00;
            tick();
        end
        chk("diag_evt", int'(e_o[0]), 3);
        chk("diag_idx", int'(fi_o[0]), 1);
        chk("diag_vld", int'(fv_o[0]), 1);
        pulse_clear();
        chk("diag_evt_clr", int'(e_o[0]), 3);
        chk("diag_idx_clr", int'(fi_o[0]), 1);
        chk("diag_vld_clr", int'(fv_o[0]), 1);
`endif

        // randomized phase, inputs biased to hold so runs reach the threshold
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 20) axis = 2'($urandom);
            if ($urandom_range(0, 99) < 10) idle = 2'($urandom);
            if ($urandom_range(0, 99) < 10) iblk = 2'($urandom);
            clear = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 199) < 1);
            tick();
        end
        reset = 1'b0; clear = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
